// File: rtl/toy_sa_drain_pkg.sv
// Shared sizing and state type for the systolic-array drain path.
// Contents:
//   V_ELEMENT_NUM   - array lanes, which is also the elements per vector register
//   V_REG_WIDTH     - width of one lane element
//   V_REG_IDX_WIDTH - VRF register index width
//   LANE_DEPTH      - per-lane de-skew FIFO depth (power of 2, >= V_ELEMENT_NUM)
//   ROW_CNT_W       - width of a row count that covers 0..V_ELEMENT_NUM
//   drain_state_e   - drain controller state
package toy_vpack;

  localparam int V_ELEMENT_NUM   = 8;
  localparam int V_REG_WIDTH     = 32;
  localparam int V_REG_IDX_WIDTH = 5;
  localparam int LANE_DEPTH      = 8;
  localparam int ROW_CNT_W       = $clog2(V_ELEMENT_NUM) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/toy_sa_drain_if.sv
// Bundles the command, array-stream and VRF write signals of the drain block.
// Modports:
//   slave  - drain block: takes commands and array data, drives VRF writes
//   master - environment: issues commands, drives the array stream, accepts writes
interface toy_sa_drain_if;
  import toy_vpack::*;

  logic                                        drain_req;
  logic                                        drain_gnt;
  logic [V_REG_IDX_WIDTH-1:0]                  drain_rd_base;
  logic [ROW_CNT_W-1:0]                        drain_row_cnt;
  logic [V_ELEMENT_NUM-1:0][V_REG_WIDTH-1:0]   sa_din;
  logic [V_ELEMENT_NUM-1:0]                    sa_load_en;
  logic [V_ELEMENT_NUM-1:0]                    sa_shift_en;
  logic                                        vrf_wr_en;
  logic                                        vrf_wr_ready;
  logic [V_REG_IDX_WIDTH-1:0]                  vrf_wr_idx;
  logic [V_ELEMENT_NUM*V_REG_WIDTH-1:0]        vrf_wr_data;
  logic                                        drain_busy;
  logic                                        drain_done;
  logic                                        drain_err;

  modport slave (
    input  drain_req, drain_rd_base, drain_row_cnt,
    input  sa_din, sa_load_en, sa_shift_en,
    input  vrf_wr_ready,
    output drain_gnt, vrf_wr_en, vrf_wr_idx, vrf_wr_data,
    output drain_busy, drain_done, drain_err
  );

  modport master (
    output drain_req, drain_rd_base, drain_row_cnt,
    output sa_din, sa_load_en, sa_shift_en,
    output vrf_wr_ready,
    input  drain_gnt, vrf_wr_en, vrf_wr_idx, vrf_wr_data,
    input  drain_busy, drain_done, drain_err
  );

endinterface

// File: rtl/toy_sa_lane_fifo.sv
// Single-lane synchronous FIFO used to de-skew one array lane.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_push     - write i_data (dropped when full unless popped in the same cycle)
//   i_pop      - consume the head entry
//   i_flush    - discard all contents; has priority over push and pop
//   i_data     - write data
//   o_data     - head entry
//   o_empty    - no stored entries
//   o_full     - DEPTH entries stored
// A push and pop in the same cycle on an empty FIFO stores nothing: the
// consumer is taking the incoming element directly (bypass in the parent).
module toy_sa_lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_do_wr;
  logic             w_do_rd;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // On full, a same-cycle pop frees the head slot, so the write may land there.
  assign w_do_rd = i_pop && !w_empty;
  assign w_do_wr = i_push && (!w_full || i_pop) && !(w_empty && i_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/toy_sa_drain.sv
// De-skews the diagonal result wavefronts shifted out of the systolic array
// and writes each completed row to the VRF as one whole vector register.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - toy_sa_drain_if.slave:
//           drain_req/gnt/rd_base/row_cnt   command
//           sa_din/sa_load_en/sa_shift_en   per-lane array stream
//           vrf_wr_en/ready/idx/data        registered row write, held until ready
//           drain_busy/done/err             status
module toy_sa_drain
  import toy_vpack::*;
(
  input  logic           clk,
  input  logic           rst_n,
  toy_sa_drain_if.slave  bus
);

  localparam int W  = V_REG_WIDTH;
  localparam int NL = V_ELEMENT_NUM;

  drain_state_e               r_state;
  logic [V_REG_IDX_WIDTH-1:0] r_base;
  logic [ROW_CNT_W-1:0]       r_cnt;
  logic [ROW_CNT_W-1:0]       r_issued;
  logic [ROW_CNT_W-1:0]       r_acc;
  logic                       r_err;
  logic                       r_wr_en;
  logic [V_REG_IDX_WIDTH-1:0] r_wr_idx;
  logic [NL*W-1:0]            r_wr_data;

  logic                       w_in_drain;
  logic [NL-1:0]              w_push;
  logic [NL-1:0]              w_empty;
  logic [NL-1:0]              w_full;
  logic [NL-1:0]              w_lane_vld;
  logic [W-1:0]               w_fifo_data [NL];
  logic [NL*W-1:0]            w_row_data;
  logic                       w_accept;
  logic                       w_load;
  logic                       w_finish;
  logic                       w_left;
  logic                       w_ovf;

  assign w_in_drain = (r_state == DRAIN);
  assign w_accept   = r_wr_en && bus.vrf_wr_ready;

  // A lane can supply its next element either from the FIFO head or, when the
  // FIFO is empty, straight from this cycle's push; that keeps the row write
  // one cycle behind the last lane's element.
  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign w_push[g]     = w_in_drain && bus.sa_load_en[g] && bus.sa_shift_en[g];
    assign w_lane_vld[g] = !w_empty[g] || w_push[g];
    assign w_row_data[g*W +: W] = w_empty[g] ? bus.sa_din[g] : w_fifo_data[g];

    toy_sa_lane_fifo #(
      .WIDTH (W),
      .DEPTH (LANE_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_pop   (w_load),
      .i_flush (w_finish),
      .i_data  (bus.sa_din[g]),
      .o_data  (w_fifo_data[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
  end

  // Never load more rows than commanded; extra data stays behind as leftover.
  assign w_load = w_in_drain && (&w_lane_vld) && (r_issued != r_cnt) &&
                  (!r_wr_en || w_accept);

  assign w_finish = w_in_drain &&
                    ((r_cnt == '0) ||
                     (w_accept && (ROW_CNT_W'(r_acc + 1'b1) == r_cnt)));

  // Data still queued (or arriving) when the drain finishes is discarded.
  assign w_left = |(~w_empty | w_push);
  assign w_ovf  = (|(w_push & w_full)) && !w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_cnt    <= '0;
      r_issued <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.drain_req) begin
            r_base   <= bus.drain_rd_base;
            r_cnt    <= bus.drain_row_cnt;
            r_issued <= '0;
            r_acc    <= '0;
            r_err    <= 1'b0;
            r_state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_load)   r_issued <= r_issued + 1'b1;
          if (w_accept) r_acc    <= r_acc + 1'b1;
          if (w_ovf || (w_finish && w_left)) r_err <= 1'b1;
          if (w_finish) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output row register: reloads on the same cycle it is accepted, so rows
  // stream at one per cycle when the VRF keeps ready high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
    end else if (w_load) begin
      r_wr_en   <= 1'b1;
      r_wr_idx  <= r_base + V_REG_IDX_WIDTH'(r_issued);
      r_wr_data <= w_row_data;
    end else if (w_accept) begin
      r_wr_en   <= 1'b0;
    end
  end

  assign bus.drain_gnt   = (r_state == IDLE);
  assign bus.drain_busy  = (r_state != IDLE);
  assign bus.drain_done  = (r_state == DONE);
  assign bus.drain_err   = r_err;
  assign bus.vrf_wr_en   = r_wr_en;
  assign bus.vrf_wr_idx  = r_wr_idx;
  assign bus.vrf_wr_data = r_wr_data;

endmodule

// File: doc/toy_sa_drain.md
Name: toy_sa_drain

Overview:
Receives the skewed result stream that the systolic array (toy_mcore) shifts out on its per-lane dout/load_en/shift_en outputs. Each diagonal wavefront is de-skewed into one full row vector. Rows are written to the vector register file as whole V-registers at rd_base + row.
It sits between toy_mcore and the vcore VRF write port. It is the reading end of the sa_din/sa_load_en/sa_shift_en interface.

Parameters:
V_ELEMENT_NUM, 8, number of array lanes = elements per vector register
V_REG_WIDTH, 32, width of one lane element
V_REG_IDX_WIDTH, 5, VRF index width
LANE_DEPTH, 8, per-lane de-skew FIFO depth (power of 2, >= V_ELEMENT_NUM)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
drain_req  in  1  start drain command valid
drain_gnt  out  1  command accepted (high only in IDLE)
drain_rd_base  in  V_REG_IDX_WIDTH  first destination VRF index
drain_row_cnt  in  $clog2(V_ELEMENT_NUM)+1  rows to drain, 0..V_ELEMENT_NUM
sa_din  in  [V_ELEMENT_NUM] x V_REG_WIDTH  per-lane array output data
sa_load_en  in  [V_ELEMENT_NUM] x 1  per-lane element valid
sa_shift_en  in  [V_ELEMENT_NUM] x 1  per-lane drain-phase qualifier
vrf_wr_en  out  1  row write valid
vrf_wr_ready  in  1  VRF accepts write
vrf_wr_idx  out  V_REG_IDX_WIDTH  destination register
vrf_wr_data  out  V_ELEMENT_NUM*V_REG_WIDTH  lane i in bits [i*W +: W]
drain_busy  out  1  state != IDLE
drain_done  out  1  one-cycle pulse at completion
drain_err  out  1  sticky overflow/leftover flag

Behaviour:
- Reset: state IDLE, FIFOs empty, row counter 0. All outputs are 0 except drain_gnt=1.
- FSM IDLE -> DRAIN -> DONE -> IDLE.
  - IDLE: drain_gnt=1. On drain_req, latch rd_base and row_cnt, clear drain_err, go to DRAIN.
  - DRAIN, row_cnt==0: go to DONE next cycle; no writes.
  - DONE: drain_done=1 for exactly one cycle, then IDLE.
- Capture: lane i pushes sa_din[i] when state==DRAIN && sa_load_en[i] && sa_shift_en[i]. The interface is ignored in IDLE and DONE.
- Overflow: a push to a full FIFO with no same-cycle pop drops the element and sets drain_err. A push and pop on a full FIFO in the same cycle is legal and loses nothing.
- Row assembly: a row is ready when every lane FIFO is non-empty.
  - vrf_wr_en, vrf_wr_idx and vrf_wr_data are registered. When a row is ready and the output register is empty, or is being accepted this cycle, load that row and pop all lanes in the same cycle.
  - Latency: the last lane element pushed in cycle t gives vrf_wr_en=1 at t+1.
- Handshake: vrf_wr_en stays high with stable idx/data until vrf_wr_ready. Back-to-back rows are sustained at one per cycle.
- Index: vrf_wr_idx = rd_base + row, wrapping modulo 2^V_REG_IDX_WIDTH.
- Completion: when the row_cnt-th write is accepted, go to DONE. If any lane FIFO is non-empty at that point, set drain_err and flush all FIFOs.
- drain_err holds until the next command is accepted.
- Reset mid-drain: everything is cleared immediately. No drain_done is issued.

Decomposition:
- toy_vpack holds V_ELEMENT_NUM, V_REG_WIDTH and V_REG_IDX_WIDTH, plus a drain_state_e enum (IDLE, DRAIN, DONE).
- Sub-module toy_sa_lane_fifo: single-lane sync FIFO with push, pop, data, empty, full and flush. It is instantiated V_ELEMENT_NUM times in a generate loop.

Test Plan:
- Skewed drain: rd_base=4, row_cnt=8. Lane i sends 0x100*i+r at cycle r+i, with wr_ready=1.
  - Required: 8 writes idx 4..11, lane i of row r = 0x100*i+r.
  - First write 1 cycle after lane 7's row-0 element; drain_done 1 cycle after the last write; drain_err=0.
- Backpressure: same stream, wr_ready low for 5 cycles mid-drain (within LANE_DEPTH).
  - Required: data/idx held stable while stalled, no loss, order preserved, drain_err=0.
- Wrap and zero-count cases:
  - rd_base=30, row_cnt=4 -> idx 30, 31, 0, 1.
  - row_cnt=0 -> drain_done 2 cycles after gnt, no vrf_wr_en.
- Overflow: lane 0 sends 9 elements while lane 7 is silent -> 9th dropped, drain_err=1 until the next drain_req is accepted.
- Leftover: row_cnt=2 but lanes deliver 3 rows -> 2 writes, then drain_err=1 and FIFOs empty in IDLE.
- Reset mid-drain: assert rst_n=0 after 3 writes -> outputs at reset values, drain_gnt=1. A fresh drain then completes normally.
